// File: rtl/esc_seq_pkg.sv
// Shared types and widths for the ESC sequencer: state and channel encodings
// and the motor speed word.
package esc_seq_pkg;

  localparam int SPD_W = 11;
  localparam int N_CH  = 4;

  typedef logic [SPD_W-1:0] spd_t;

  typedef enum logic [1:0] {DISARMED, ARMING, RUN, FAILSAFE} esc_state_t;
  typedef enum logic [1:0] {CH_FRNT, CH_BCK, CH_LFT, CH_RGHT} esc_ch_t;

endpackage

// File: rtl/esc_seq_if.sv
// Command/status bundle between the flight controller and the ESC sequencer.
// The master drives arm/disarm/commands; the slave returns speeds and status.
interface esc_seq_if;
  import esc_seq_pkg::*;

  logic arm;
  logic disarm;
  logic cmd_vld;
  spd_t frnt_cmd;
  spd_t bck_cmd;
  spd_t lft_cmd;
  spd_t rght_cmd;
  spd_t frnt_spd;
  spd_t bck_spd;
  spd_t lft_spd;
  spd_t rght_spd;
  logic frame_tick;
  logic upd_done;
  logic armed;
  logic failsafe;

  modport master (
    output arm, disarm, cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    input  frnt_spd, bck_spd, lft_spd, rght_spd,
    input  frame_tick, upd_done, armed, failsafe
  );

  modport slave (
    input  arm, disarm, cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd,
    output frnt_spd, bck_spd, lft_spd, rght_spd,
    output frame_tick, upd_done, armed, failsafe
  );

endinterface

// File: rtl/esc_sequencer_slew_step.sv
// One slew-limited step of a speed toward its target; shared by all channels.
// Arithmetic is one bit wider than the speed so neither direction can wrap.
module slew_step
  import esc_seq_pkg::*;
(
  input  spd_t i_cur,
  input  spd_t i_tgt,
  input  spd_t i_slew,
  output spd_t o_nxt
);

  logic [SPD_W:0] w_up;
  logic [SPD_W:0] w_dn;

  assign w_up = {1'b0, i_cur} + {1'b0, i_slew};
  assign w_dn = {1'b0, i_cur} - {1'b0, i_slew};

  // NOTE: o_nxt gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    o_nxt = i_cur;
    if (i_tgt > i_cur) begin
      o_nxt = (w_up >= {1'b0, i_tgt}) ? i_tgt : w_up[SPD_W-1:0];
    end else if (i_tgt < i_cur) begin
      // w_dn[SPD_W] set means the step would go below zero
      o_nxt = (w_dn[SPD_W] || (w_dn[SPD_W-1:0] <= i_tgt)) ? i_tgt : w_dn[SPD_W-1:0];
    end
  end

endmodule

// File: rtl/esc_sequencer.sv
// ESC sequencer: arming, command watchdog/failsafe and per-frame slew limiting
// of four motor speeds through one time-multiplexed limiter.
module esc_sequencer
  import esc_seq_pkg::*;
#(
  parameter int   PERIOD_WIDTH   = 20,
  parameter spd_t SLEW           = 11'd64,
  parameter int   ARM_FRAMES     = 8,
  parameter int   TIMEOUT_FRAMES = 25
) (
  input  logic        clk,
  input  logic        rst,
  esc_seq_if.slave    bus
);

  localparam int ARM_W = $clog2(ARM_FRAMES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_FRAMES + 1);

  logic [PERIOD_WIDTH-1:0] r_frame_cnt;
  esc_state_t              r_state;
  esc_state_t              w_state_nxt;
  logic [ARM_W-1:0]        r_arm_cnt;
  logic [WD_W-1:0]         r_wdog;
  spd_t                    r_tgt [N_CH];
  spd_t                    r_spd [N_CH];
  logic                    r_seq_act;
  esc_ch_t                 r_ch;
  logic                    r_upd_done;

  logic w_frame_tick;
  logic w_all_zero;
  logic w_armed;
  logic w_failsafe;
  logic w_seq_start;
  spd_t w_cur;
  spd_t w_tgt;
  spd_t w_nxt;

  assign w_frame_tick = &r_frame_cnt;
  assign w_all_zero   = (r_spd[CH_FRNT] == '0) && (r_spd[CH_BCK] == '0) &&
                        (r_spd[CH_LFT] == '0)  && (r_spd[CH_RGHT] == '0);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_frame_cnt <= '0;
    else     r_frame_cnt <= r_frame_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= DISARMED;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.disarm) begin
      w_state_nxt = DISARMED;
    end else begin
      case (r_state)
        DISARMED: if (bus.arm) w_state_nxt = ARMING;
        ARMING:   if (w_frame_tick && (int'(r_arm_cnt) + 1 == ARM_FRAMES)) w_state_nxt = RUN;
        RUN:      if (w_frame_tick && !bus.cmd_vld &&
                      (int'(r_wdog) + 1 >= TIMEOUT_FRAMES)) w_state_nxt = FAILSAFE;
        FAILSAFE: if (r_upd_done && w_all_zero) w_state_nxt = DISARMED;
        default:  w_state_nxt = DISARMED;
      endcase
    end
    w_armed     = (r_state == RUN) || (r_state == FAILSAFE);
    w_failsafe  = (r_state == FAILSAFE);
    w_seq_start = w_frame_tick && w_armed;
  end

  // Leaving ARMING or RUN resets the counter, which also clears it on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arm_cnt <= '0;
      r_wdog    <= '0;
    end else begin
      if (r_state != ARMING)  r_arm_cnt <= '0;
      else if (w_frame_tick)  r_arm_cnt <= r_arm_cnt + 1'b1;
      if (r_state != RUN)     r_wdog <= '0;
      else if (bus.cmd_vld)   r_wdog <= '0;
      else if (w_frame_tick)  r_wdog <= r_wdog + 1'b1;
    end
  end

  // NOTE: these small register arrays are reset explicitly; their reset values are visible behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_tgt[i] <= '0;
    end else if (bus.cmd_vld) begin
      r_tgt[CH_FRNT] <= bus.frnt_cmd;
      r_tgt[CH_BCK]  <= bus.bck_cmd;
      r_tgt[CH_LFT]  <= bus.lft_cmd;
      r_tgt[CH_RGHT] <= bus.rght_cmd;
    end
  end

  assign w_cur = r_spd[r_ch];
  assign w_tgt = (r_state == RUN) ? r_tgt[r_ch] : '0;

  slew_step u_slew_step (
    .i_cur  (w_cur),
    .i_tgt  (w_tgt),
    .i_slew (SLEW),
    .o_nxt  (w_nxt)
  );

  // Disarm cuts all motors on the same edge and aborts any running sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_spd[i] <= '0;
      r_seq_act  <= 1'b0;
      r_ch       <= CH_FRNT;
      r_upd_done <= 1'b0;
    end else begin
      r_upd_done <= 1'b0;
      if (bus.disarm || (r_state == DISARMED)) begin
        for (int i = 0; i < N_CH; i++) r_spd[i] <= '0;
        r_seq_act <= 1'b0;
        r_ch      <= CH_FRNT;
      end else if (r_seq_act) begin
        r_spd[r_ch] <= w_nxt;
        if (r_ch == CH_RGHT) begin
          r_seq_act  <= 1'b0;
          r_upd_done <= 1'b1;
        end else begin
          r_ch <= esc_ch_t'(r_ch + 1'b1);
        end
      end else if (w_seq_start) begin
        r_seq_act <= 1'b1;
        r_ch      <= CH_FRNT;
      end
    end
  end

  assign bus.frnt_spd   = r_spd[CH_FRNT];
  assign bus.bck_spd    = r_spd[CH_BCK];
  assign bus.lft_spd    = r_spd[CH_LFT];
  assign bus.rght_spd   = r_spd[CH_RGHT];
  assign bus.frame_tick = w_frame_tick;
  assign bus.upd_done   = r_upd_done;
  assign bus.armed      = w_armed;
  assign bus.failsafe   = w_failsafe;

endmodule

// File: tb/tb_esc_sequencer.sv
// Directed bench for esc_sequencer with a 16-clk frame, SLEW=64, ARM_FRAMES=2
// and TIMEOUT_FRAMES=3; expected speeds are hand-computed per frame.
module tb_esc_sequencer;
  import esc_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;

  esc_seq_if bus ();

  esc_sequencer #(
    .PERIOD_WIDTH   (4),
    .SLEW           (11'd64),
    .ARM_FRAMES     (2),
    .TIMEOUT_FRAMES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    spd_t cmd;
    spd_t exp;
  } frame_vec_t;

  frame_vec_t vecs [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cmds(input spd_t v);
    bus.frnt_cmd = v;
    bus.bck_cmd  = v;
    bus.lft_cmd  = v;
    bus.rght_cmd = v;
  endtask

  task automatic pulse_cmd(input spd_t v);
    set_cmds(v);
    bus.cmd_vld = 1'b1;
    step();
    bus.cmd_vld = 1'b0;
  endtask

  // Returns in the cycle where frame_tick is high; an expired bound is a failed check.
  task automatic wait_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus.frame_tick && n < 40);
    check("frame_tick_wait", bus.frame_tick, 1);
  endtask

  task automatic check_all_spd(input string name, input spd_t v);
    check({name, "_frnt"}, bus.frnt_spd, v);
    check({name, "_bck"},  bus.bck_spd,  v);
    check({name, "_lft"},  bus.lft_spd,  v);
    check({name, "_rght"}, bus.rght_spd, v);
  endtask

  // One update frame: frnt changes in T+2, rght and upd_done in T+5.
  task automatic run_frame(input spd_t cmd, input spd_t exp, input spd_t prv, input bit drive);
    if (drive) pulse_cmd(cmd);
    wait_tick();
    check("frnt_at_tick", bus.frnt_spd, prv);
    step();
    step();
    check("frnt_t2", bus.frnt_spd, exp);
    check("bck_t2_old", bus.bck_spd, prv);
    step();
    step();
    check("upd_done_t4", bus.upd_done, 0);
    check("rght_t4_old", bus.rght_spd, prv);
    step();
    check("upd_done_t5", bus.upd_done, 1);
    check("bck_t5", bus.bck_spd, exp);
    check("lft_t5", bus.lft_spd, exp);
    check("rght_t5", bus.rght_spd, exp);
  endtask

  task automatic arm_to_run(input bit with_cmd, input spd_t v);
    bus.arm = 1'b1;
    if (with_cmd) begin
      set_cmds(v);
      bus.cmd_vld = 1'b1;
    end
    step();
    bus.arm     = 1'b0;
    bus.cmd_vld = 1'b0;
    wait_tick();
    wait_tick();
    check("armed_before_run", bus.armed, 0);
    step();
    check("armed_in_run", bus.armed, 1);
    check("failsafe_in_run", bus.failsafe, 0);
  endtask

  task automatic ramp_to_300();
    run_frame(11'd300, 11'd64,  11'd0,   1'b1);
    run_frame(11'd300, 11'd128, 11'd64,  1'b1);
    run_frame(11'd300, 11'd192, 11'd128, 1'b1);
    run_frame(11'd300, 11'd256, 11'd192, 1'b1);
    run_frame(11'd300, 11'd300, 11'd256, 1'b1);
  endtask

  task automatic count_to_tick(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus.frame_tick && n < 40);
    check(name, n, 15);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    spd_t prv;
    spd_t fs_exp [4];

    vecs = '{
      '{11'd500, 11'd64},  '{11'd500, 11'd128}, '{11'd500, 11'd192}, '{11'd500, 11'd256},
      '{11'd500, 11'd320}, '{11'd500, 11'd384}, '{11'd500, 11'd448}, '{11'd500, 11'd500},
      '{11'd100, 11'd436}, '{11'd100, 11'd372}, '{11'd100, 11'd308}, '{11'd100, 11'd244},
      '{11'd100, 11'd180}, '{11'd100, 11'd116}, '{11'd100, 11'd100}, '{11'd100, 11'd100},
      '{11'd300, 11'd164}, '{11'd300, 11'd228}, '{11'd300, 11'd292}, '{11'd300, 11'd300}
    };
    fs_exp = '{11'd172, 11'd108, 11'd44, 11'd0};

    rst         = 1'b1;
    bus.arm     = 1'b0;
    bus.disarm  = 1'b0;
    bus.cmd_vld = 1'b0;
    set_cmds(11'd0);
    repeat (3) step();

    // Reset state
    check_all_spd("reset", 11'd0);
    check("reset_armed", bus.armed, 0);
    check("reset_failsafe", bus.failsafe, 0);
    check("reset_upd_done", bus.upd_done, 0);
    check("reset_frame_tick", bus.frame_tick, 0);
    rst = 1'b0;
    count_to_tick("first_tick_clks");

    // Arm, ramp up, ramp down, ramp to 300
    arm_to_run(1'b1, 11'd500);
    prv = 11'd0;
    for (int i = 0; i < 20; i++) begin
      run_frame(vecs[i].cmd, vecs[i].exp, prv, 1'b1);
      prv = vecs[i].exp;
    end

    // Watchdog timeout from 300: two quiet frames, then failsafe on the third tick
    run_frame(11'd0, 11'd300, 11'd300, 1'b0);
    check("failsafe_before_timeout", bus.failsafe, 0);
    run_frame(11'd0, 11'd236, 11'd300, 1'b0);
    check("failsafe_after_timeout", bus.failsafe, 1);
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    prv = 11'd236;
    for (int i = 0; i < 4; i++) begin
      run_frame(11'd0, fs_exp[i], prv, 1'b0);
      prv = fs_exp[i];
    end
    check("failsafe_at_last_upd", bus.failsafe, 1);
    step();
    check("armed_after_failsafe", bus.armed, 0);
    check("failsafe_cleared", bus.failsafe, 0);

    // Disarm in T+2 of a sequence at 300
    arm_to_run(1'b1, 11'd300);
    ramp_to_300();
    pulse_cmd(11'd300);
    wait_tick();
    step();
    step();
    check("frnt_before_disarm", bus.frnt_spd, 300);
    bus.disarm = 1'b1;
    step();
    bus.disarm = 1'b0;
    check_all_spd("disarm_cut", 11'd0);
    check("disarm_armed", bus.armed, 0);
    step();
    check("disarm_upd_t4", bus.upd_done, 0);
    step();
    check("disarm_upd_t5", bus.upd_done, 0);

    // arm together with disarm stays DISARMED
    bus.arm    = 1'b1;
    bus.disarm = 1'b1;
    step();
    bus.arm    = 1'b0;
    bus.disarm = 1'b0;
    wait_tick();
    wait_tick();
    step();
    check("arm_disarm_together", bus.armed, 0);

    // cmd_vld on the frame_tick cycle clears the watchdog
    arm_to_run(1'b0, 11'd0);
    wait_tick();
    set_cmds(11'd0);
    bus.cmd_vld = 1'b1;
    step();
    bus.cmd_vld = 1'b0;
    wait_tick();
    wait_tick();
    step();
    check("no_failsafe_after_two", bus.failsafe, 0);
    check("still_armed_after_two", bus.armed, 1);
    wait_tick();
    step();
    check("failsafe_after_three", bus.failsafe, 1);
    repeat (5) step();
    check("disarmed_after_zero_fs", bus.armed, 0);

    // Synchronous reset mid-sequence at 300
    arm_to_run(1'b1, 11'd300);
    ramp_to_300();
    pulse_cmd(11'd300);
    wait_tick();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_spd("midrst", 11'd0);
    check("midrst_armed", bus.armed, 0);
    check("midrst_failsafe", bus.failsafe, 0);
    check("midrst_upd_done", bus.upd_done, 0);
    count_to_tick("tick_after_midrst");
    arm_to_run(1'b0, 11'd0);
    run_frame(11'd0, 11'd0, 11'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/esc_sequencer.md
Name: esc_sequencer

Overview:
- Controller in front of the four ESC PWM generators of the flight controller.
- Owns arming, the command watchdog and failsafe, and per-frame slew limiting of the four 11-bit motor speed settings.
- Runs a free-running frame counter matching the ESC PWM period, and applies new speeds once per frame.
- Uses one shared slew limiter, time-multiplexed across the four channels.

Parameters:
- PERIOD_WIDTH, 20, frame counter width; one frame = 2^PERIOD_WIDTH clks.
- SLEW, 11'd64, max change of any speed per frame, applies up and down.
- ARM_FRAMES, 8, frames held at zero speed after arm before RUN.
- TIMEOUT_FRAMES, 25, frame ticks in RUN without cmd_vld before failsafe.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- arm  in  1  request arming, level or pulse
- disarm  in  1  immediate motor cut
- cmd_vld  in  1  latch the four *_cmd inputs into the target registers
- frnt_cmd, bck_cmd, lft_cmd, rght_cmd  in  11 each  requested speeds
- frnt_spd, bck_spd, lft_spd, rght_spd  out  11 each  registered speeds to the ESC SPEED inputs
- frame_tick  out  1  high one clk when the frame counter is all ones
- upd_done  out  1  one-clk pulse when all four channels have been updated for the frame
- armed  out  1  high in RUN or FAILSAFE
- failsafe  out  1  high in FAILSAFE

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset values:
  - All *_spd = 0, frame counter = 0, targets = 0, watchdog = 0.
  - State = DISARMED; frame_tick, upd_done, armed and failsafe all 0.
- Frame counter: increments every clk and wraps; frame_tick is combinational on the counter being all ones.
- Target latch: on cmd_vld the four *_cmd values are captured in every state. Latched targets are used only in RUN.
- Update sequence, when frame_tick is high in cycle T:
  - Channels frnt, bck, lft, rght are processed in cycles T+1 to T+4, one per cycle, through the shared limiter.
  - New values are visible in T+2, T+3, T+4 and T+5 respectively.
  - upd_done is high in T+5.
- Slew rule (unsigned, 11 bits):
  - If |target − spd| ≤ SLEW, then spd = target.
  - Else spd moves by SLEW toward target.
  - No overshoot and no wrap: compute in 12 bits and clamp.
- Effective target: the latched target in RUN, and 0 in FAILSAFE.
- While the sequencer is idle between frames, or in DISARMED or ARMING, spd values are held.
- States:
  - DISARMED: spd forced to 0. If arm=1 and disarm=0, go to ARMING and clear arm_cnt.
  - ARMING: spd held at 0.
    - Each frame_tick increments arm_cnt; go to RUN on the tick where arm_cnt reaches ARM_FRAMES.
    - The watchdog is cleared on entry to RUN.
  - RUN:
    - Each frame runs the slew sequence.
    - Watchdog: increments on frame_tick, clears on cmd_vld. If both occur in the same cycle, it clears.
    - When the watchdog reaches TIMEOUT_FRAMES, go to FAILSAFE.
  - FAILSAFE:
    - Slew down to 0; arm is ignored.
    - Go to DISARMED in the upd_done cycle in which all four spd == 0.
- Disarm has highest priority:
  - disarm=1 in any state → DISARMED next cycle, and all spd = 0 on that same edge, with no slew.
  - Any in-flight update sequence is aborted and upd_done is not pulsed.
- arm and disarm together: disarm wins.
- rst asserted mid-operation, including mid-sequence: all registers return to their reset values on that edge.
- Latency: cmd_vld to first speed change is at most one frame + 2 clks.

Decomposition:
- Package esc_seq_pkg holds:
  - SPD_W = 11.
  - typedef enum logic [1:0] {DISARMED, ARMING, RUN, FAILSAFE} esc_state_t.
  - typedef enum logic [1:0] {CH_FRNT, CH_BCK, CH_LFT, CH_RGHT} esc_ch_t.
- One sub-module, slew_step: combinational, inputs cur, tgt and slew, output nxt. It is instantiated once and shared by channel index.

Test Plan (PERIOD_WIDTH=4, so a tick every 16 clks; SLEW=64, ARM_FRAMES=2, TIMEOUT_FRAMES=3):
- Reset, then arm pulse and cmd_vld with all cmds=500, cmd_vld repeated each frame → armed=1 after 2 ticks; frnt_spd goes 64, 128 … 448, 500 on successive frames; rght_spd changes 3 clks after frnt_spd; upd_done is high in T+5.
- In RUN at spd=500, cmd all=100 → 436, 372, 308, 244, 180, 116, 100; spd never goes below target.
- In RUN at 300, no cmd_vld for 3 ticks → failsafe=1; spd goes 236, 172, 108, 44, 0; then DISARMED with armed=0 and failsafe=0.
- disarm in cycle T+2 of a sequence, with spd=300 → all spd=0 next clk, upd_done not pulsed, armed=0.
- arm and disarm together in DISARMED → stays DISARMED. In RUN, cmd_vld coinciding with frame_tick → watchdog is 0 and no failsafe after 2 further ticks.
- rst held high for 1 clk mid-RUN with spd=300 → next clk all spd=0, state DISARMED, targets 0, and frame counter restarts at 0.
